// File: rtl/apb3_slave_regbank.sv
// APB3 completer holding NUM_REGS word-spaced read/write registers with programmable wait states.
// Define APB3_SLVERR_EN to flag misaligned/out-of-range transfers on PSLVERR; otherwise misses complete silently.
module apb3_slave_regbank #(
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned        WAIT_STATES = 0
) (
    input  logic                         SYSCLK,
    input  logic                         NSYSRESET,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   REG_OUT,
    output logic [NUM_REGS-1:0]          WR_PULSE
);

    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WCNT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e              state_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                hit_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q;

    logic [ADDR_W-1:0]   off_c;
    logic                hit_c;
    logic [IDX_W-1:0]    idx_c;
    logic                pready_c;
    logic                do_write_c;
    logic                do_read_c;
    logic [DATA_W-1:0]   prdata_c;

    // Address decode relative to the bank base; wraps modulo 2**ADDR_W.
    always_comb begin
        off_c = PADDR - BASE_ADDR;
        hit_c = (off_c[1:0] == 2'b00) && ((off_c >> 2) < ADDR_W'(NUM_REGS));
        idx_c = off_c[IDX_W+1:2];
    end

    always_comb begin
        pready_c   = (state_q == ACCESS) && PSEL && (wcnt_q == WCNT_W'(WAIT_STATES));
        do_write_c = pready_c && write_q && hit_q;
        do_read_c  = pready_c && !write_q && hit_q;
    end

    // Transfer FSM: setup phase latches the decoded request, access phase counts wait states.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= ACCESS;
                        wcnt_q  <= '0;
                        idx_q   <= idx_c;
                        hit_q   <= hit_c;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                    end
                end
                ACCESS: begin
                    if (!PSEL || pready_c) begin
                        state_q <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + WCNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register file commit and one-cycle write strobe.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse_q[i] <= do_write_c && (idx_q == IDX_W'(i));
                if (do_write_c && (idx_q == IDX_W'(i))) begin
                    regs_q[i] <= wdata_q;
                end
            end
        end
    end

    always_comb begin
        prdata_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (do_read_c && (idx_q == IDX_W'(i))) begin
                prdata_c = regs_q[i];
            end
        end
    end

    assign PREADY   = pready_c;
    assign PRDATA   = prdata_c;
    assign WR_PULSE = wr_pulse_q;

`ifdef APB3_SLVERR_EN
    assign PSLVERR = pready_c && !hit_q;
`else
    assign PSLVERR = 1'b0;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign REG_OUT[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_apb3_slave_regbank.sv
// Directed bench for apb3_slave_regbank: a zero-wait-state instance and a three-wait-state instance.
module tb_apb3_slave_regbank;

`ifdef APB3_SLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         psel0, psel3, penable, pwrite, use3;
    logic [31:0]  paddr, pwdata;
    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [255:0] reg_out0, reg_out3;
    logic [7:0]   wr_pulse0, wr_pulse3;
    logic [31:0]  prdata_m;
    logic         pready_m, pslverr_m;

    logic [7:0][31:0] exp0;
    logic [7:0][31:0] exp3;

    int checks = 0;
    int errors = 0;

    apb3_slave_regbank #(.WAIT_STATES(0)) u_dut0 (
        .SYSCLK(clk), .NSYSRESET(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
        .REG_OUT(reg_out0), .WR_PULSE(wr_pulse0));

    apb3_slave_regbank #(.WAIT_STATES(3)) u_dut3 (
        .SYSCLK(clk), .NSYSRESET(rst_n), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
        .REG_OUT(reg_out3), .WR_PULSE(wr_pulse3));

    assign pready_m  = use3 ? pready3  : pready0;
    assign prdata_m  = use3 ? prdata3  : prdata0;
    assign pslverr_m = use3 ? pslverr3 : pslverr0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One APB transfer; returns 1 time unit after the edge that ends the PREADY cycle.
    task automatic apb_xfer(input logic on3, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] rdata,
                            output logic err, output int cycles);
        use3 = on3; paddr = addr; pwrite = wr; pwdata = data; penable = 1'b0;
        if (on3) psel3 = 1'b1; else psel0 = 1'b1;
        cycles = 1; rdata = 'x; err = 1'bx;
        @(posedge clk); #1; penable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycles++;
            @(negedge clk);
            if (pready_m === 1'b1) begin
                rdata = prdata_m; err = pslverr_m;
                @(posedge clk); #1;
                psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL xfer_timeout addr=%h got no PREADY required PREADY within 20 cycles", addr);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0; use3 = 0;
        paddr = '0; pwdata = '0; exp0 = '0; exp3 = '0;
        #1 rst_n = 1'b0;
        #3;
        checks++; if (reg_out0 !== 256'h0) begin errors++; $display("FAIL reset_reg_out got %h required 0", reg_out0); end
        checks++; if (wr_pulse0 !== 8'h0) begin errors++; $display("FAIL reset_wr_pulse got %h required 0", wr_pulse0); end
        checks++; if ({pready0, pslverr0, prdata0} !== 34'h0) begin errors++; $display("FAIL reset_apb_out got %h required 0", {pready0, pslverr0, prdata0}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int cyc;
        apb_xfer(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, rd, er, cyc);
        exp0[2] = 32'hDEADBEEF;
        checks++; if (cyc !== 2) begin errors++; $display("FAIL wr_latency got %0d required 2", cyc); end
        checks++; if (wr_pulse0 !== 8'b0000_0100) begin errors++; $display("FAIL wr_pulse got %b required 00000100", wr_pulse0); end
        checks++; if (reg_out0[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL reg2_out got %h required deadbeef", reg_out0[95:64]); end
        @(posedge clk); #1;
        checks++; if (wr_pulse0 !== 8'h0) begin errors++; $display("FAIL wr_pulse_clear got %b required 0", wr_pulse0); end
        apb_xfer(1'b0, 1'b0, 32'h08, 32'h0, rd, er, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL rd_latency got %0d required 2", cyc); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h required deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got %b required 0", er); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int cyc;
        apb_xfer(1'b1, 1'b0, 32'h00, 32'h0, rd, er, cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL ws3_latency got %0d required 5", cyc); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ws3_rd_data got %h required 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int cyc;
        apb_xfer(1'b0, 1'b1, 32'h00, 32'h11, rd, er, cyc);
        checks++; if (cyc !== 2 || wr_pulse0 !== 8'h01) begin errors++; $display("FAIL b2b_w0 got cyc=%0d pulse=%b required 2/00000001", cyc, wr_pulse0); end
        apb_xfer(1'b0, 1'b1, 32'h04, 32'h22, rd, er, cyc);
        checks++; if (cyc !== 2 || wr_pulse0 !== 8'h02) begin errors++; $display("FAIL b2b_w1 got cyc=%0d pulse=%b required 2/00000010", cyc, wr_pulse0); end
        apb_xfer(1'b0, 1'b1, 32'h1C, 32'h33, rd, er, cyc);
        checks++; if (cyc !== 2 || wr_pulse0 !== 8'h80) begin errors++; $display("FAIL b2b_w7 got cyc=%0d pulse=%b required 2/10000000", cyc, wr_pulse0); end
        exp0[0] = 32'h11; exp0[1] = 32'h22; exp0[7] = 32'h33;
        apb_xfer(1'b0, 1'b0, 32'h1C, 32'h0, rd, er, cyc);
        checks++; if (rd !== 32'h33) begin errors++; $display("FAIL rd_after_wr got %h required 33", rd); end
        checks++; if (reg_out0 !== exp0) begin errors++; $display("FAIL b2b_regs got %h required %h", reg_out0, exp0); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int cyc;
        apb_xfer(1'b0, 1'b1, 32'h20, 32'h12345678, rd, er, cyc);
        checks++; if (cyc !== 2 || er !== EXP_ERR) begin errors++; $display("FAIL miss_wr got cyc=%0d err=%b required 2/%b", cyc, er, EXP_ERR); end
        checks++; if (wr_pulse0 !== 8'h0) begin errors++; $display("FAIL miss_wr_pulse got %b required 0", wr_pulse0); end
        checks++; if (reg_out0 !== exp0) begin errors++; $display("FAIL miss_wr_regs got %h required %h", reg_out0, exp0); end
        apb_xfer(1'b0, 1'b0, 32'h06, 32'h0, rd, er, cyc);
        checks++; if (cyc !== 2 || er !== EXP_ERR) begin errors++; $display("FAIL misalign_rd got cyc=%0d err=%b required 2/%b", cyc, er, EXP_ERR); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rd_data got %h required 0", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int cyc;
        use3 = 1'b1; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h55; psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        checks++; if (pready3 !== 1'b0) begin errors++; $display("FAIL abort_acc1 got PREADY=%b required 0", pready3); end
        @(posedge clk); #1; psel3 = 1'b0;
        @(negedge clk);
        checks++; if (pready3 !== 1'b0) begin errors++; $display("FAIL abort_acc2 got PREADY=%b required 0", pready3); end
        @(posedge clk); #1; penable = 1'b0;
        checks++; if (wr_pulse3 !== 8'h0 || reg_out3 !== exp3) begin errors++; $display("FAIL abort_nowrite got pulse=%b regs=%h required 0", wr_pulse3, reg_out3); end
        apb_xfer(1'b1, 1'b0, 32'h0C, 32'h0, rd, er, cyc);
        checks++; if (cyc !== 5 || rd !== 32'h0) begin errors++; $display("FAIL abort_reread got cyc=%0d data=%h required 5/0", cyc, rd); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic er; int cyc;
        apb_xfer(1'b0, 1'b1, 32'h10, 32'hFF, rd, er, cyc);
        checks++; if (reg_out0[159:128] !== 32'hFF || wr_pulse0 !== 8'h10) begin errors++; $display("FAIL pre_rst_wr got reg4=%h pulse=%b required ff/00010000", reg_out0[159:128], wr_pulse0); end
        use3 = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hAA; psel0 = 1'b1; penable = 1'b0;
        @(posedge clk); #1; penable = 1'b1;
        #2;
        checks++; if (pready0 !== 1'b1) begin errors++; $display("FAIL pre_rst_ready got %b required 1", pready0); end
        rst_n = 1'b0;
        #1;
        exp0 = '0; exp3 = '0;
        checks++; if (pready0 !== 1'b0 || wr_pulse0 !== 8'h0 || reg_out0 !== 256'h0) begin errors++; $display("FAIL async_rst got ready=%b pulse=%b regs=%h required 0", pready0, wr_pulse0, reg_out0); end
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (reg_out0 !== 256'h0) begin errors++; $display("FAIL post_rst_regs got %h required 0", reg_out0); end
        apb_xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, er, cyc);
        checks++; if (rd !== 32'h0 || cyc !== 2) begin errors++; $display("FAIL post_rst_rd got data=%h cyc=%0d required 0/2", rd, cyc); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_back_to_back();
        test_errors();
        test_abort();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
